bcd_display_scanner: RTL and testbench
======================================

// Module: bcd_display_scanner
// PURPOSE
//  Sequences the shared decoderBCD datapath for a 2-digit multiplexed 7-segment display.
//  Accepts a 5-bit binary value (0..31) over a valid/ready handshake and registers it.
//  Drives decoderBCD with the registered value and latches its tens/ones digits.
//  Time-multiplexes both digits onto one segment bus, with optional leading-zero blanking.
//  Sits between the result producer and the board display pins.
// PARAMETERS
//  SCAN_DIV  4  clock cycles each digit is lit; legal range >= 2
//  BLANK_LZ  1  1: blank the tens digit when it is 0; 0: always show it
// PORTS
//  clk          in   1  single system clock; all state updates on rising edge
//  rst_n        in   1  synchronous, active-low reset
//  en           in   1  display enable; low forces IDLE
//  in_valid     in   1  value_in is valid this cycle
//  value_in     in   5  binary value 0..31
//  in_ready     out  1  block accepts value_in this cycle
//  seg          out  7  segments {g,f,e,d,c,b,a}, active high
//  an           out  2  digit enable, one-hot active high; an[0]=ones, an[1]=tens
//  frame_done   out  1  1-cycle pulse on the last cycle of the tens slot
// BEHAVIOUR
//  - Reset: state=IDLE; val_q, d1_q, d0_q, div, sel all 0; seg=0, an=00, frame_done=0.
//    in_ready=en while rst_n is high. Reset asserted mid-scan takes effect at the next edge.
//  - FSM states: IDLE, LOAD, SCAN. seg, an, in_ready and frame_done are decoded
//    combinationally from registers only.
//  - Handshake: a transfer occurs when in_valid && in_ready. On a transfer, val_q<=value_in
//    and the next state is LOAD. Without a transfer, value_in is ignored.
//  - IDLE: an=00, seg=0, in_ready=en.
//  - LOAD (1 cycle):
//    - in_ready=0, an=00.
//    - decoderBCD in=val_q; d1_q<=out1, d0_q<=out0.
//    - div<=0, sel<=0; next state SCAN (IDLE if en=0).
//  - SCAN:
//    - an=(sel?10:01); seg=ENC(sel?d1_q:d0_q).
//    - If sel=1 && d1_q==0 && BLANK_LZ=1, then seg=0 while an=10 stays asserted.
//    - div counts 0..SCAN_DIV-1; at SCAN_DIV-1, div<=0 and sel<=~sel.
//    - frame_end = (div==SCAN_DIV-1)&&(sel==1); frame_done=frame_end; in_ready=frame_end&&en.
//    - Transfer at frame_end -> LOAD. Otherwise scanning continues with the held digits.
//      New values are only accepted at frame boundaries, so a frame never mixes two values.
//  - en=0 in any state -> IDLE at the next edge; an=00 from that edge on. d1_q/d0_q are held.
//  - Latency: transfer at edge N -> LOAD during cycle N..N+1. First lit ones digit appears
//    after edge N+1 and lasts SCAN_DIV cycles, followed by the tens digit for SCAN_DIV cycles.
//  - ENC: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101
//    7=0000111 8=1111111 9=1101111; codes 10..15 -> 0000000 (unreachable, blank).
//  - div width = $clog2(SCAN_DIV). Tens digit max 3, ones digit max 9.
//  - in_valid during LOAD or mid-frame: not accepted; in_ready=0 and the producer must hold.
// TESTING
//  1. rst_n=0 for 2 edges, en=1 -> an=00, seg=0, frame_done=0, in_ready=1 after release.
//  2. SCAN_DIV=4, transfer 31 -> LOAD 1 cycle; an=01 seg=0000110 for 4 cycles;
//     an=10 seg=1001111 for 4 cycles; frame_done=1 only on the 8th cycle; then repeats.
//  3. BLANK_LZ=1, transfer 7 -> ones slot seg=0000111; tens slot an=10, seg=0000000.
//     BLANK_LZ=0 -> tens slot seg=0111111.
//  4. Showing 12: in_valid with 19 mid-frame -> in_ready=0, display stays 1,2.
//     19 is accepted at frame_end; the next frame shows 9 then 1.
//  5. en=0 mid-SCAN -> an=00 next cycle, state IDLE.
//     rst_n=0 mid-SCAN -> all reset values next edge.
//  6. Sweep value_in 0..31, one transfer per frame -> d1_q==v/10, d0_q==v%10, seg per ENC.

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// bcd_display_scanner_if: value handshake and display pins of the 2-digit scanner
interface bcd_display_scanner_if;
   logic       en;
   logic       in_valid;
   logic [4:0] value_in;
   logic       in_ready;
   logic [6:0] seg;
   logic [1:0] an;
   logic       frame_done;
   modport master (output en, in_valid, value_in, input in_ready, seg, an, frame_done);
   modport slave (input en, in_valid, value_in, output in_ready, seg, an, frame_done);
endinterface

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: accepts a 5-bit value and time-multiplexes its two decimal
// digits onto a shared 7-segment bus, optionally blanking a leading zero
module decoder_bcd (
   input  logic [4:0] bin,
   output logic [3:0] out1,
   output logic [3:0] out0
);
   logic [1:0] tens;
   always_comb begin
      tens = bin >= 5'd30 ? 2'd3 : bin >= 5'd20 ? 2'd2 : bin >= 5'd10 ? 2'd1 : 2'd0;
      out1 = {2'b00, tens};
      out0 = 4'(bin - {tens, 3'b000} - {2'b00, tens, 1'b0});
   end
endmodule

module bcd_display_scanner #(
   parameter int SCAN_DIV = 4,
   parameter bit BLANK_LZ = 1'b1
) (
   input logic                clk,
   input logic                rst_n,
   bcd_display_scanner_if.slave bus
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;
   state_t state, state_nxt;
   logic [4:0] val_q;
   logic [3:0] d1_q, d0_q, out1, out0, digit;
   logic [DW-1:0] div;
   logic sel, scan, frame_end, ready, xfer;
   decoder_bcd u_dec (.bin(val_q), .out1(out1), .out0(out0));
   function automatic logic [6:0] enc(input logic [3:0] d);
      case (d)
         4'd0:    enc = 7'b0111111;
         4'd1:    enc = 7'b0000110;
         4'd2:    enc = 7'b1011011;
         4'd3:    enc = 7'b1001111;
         4'd4:    enc = 7'b1100110;
         4'd5:    enc = 7'b1101101;
         4'd6:    enc = 7'b1111101;
         4'd7:    enc = 7'b0000111;
         4'd8:    enc = 7'b1111111;
         4'd9:    enc = 7'b1101111;
         default: enc = 7'b0000000;
      endcase
   endfunction
   // new values are taken only between frames so one frame never mixes two values
   always_comb begin
      scan = state == SCAN;
      frame_end = scan && div == DIV_LAST && sel;
      ready = bus.en && (state == IDLE || frame_end);
      xfer = bus.in_valid && ready;
      digit = sel ? d1_q : d0_q;
      bus.in_ready = ready;
      bus.frame_done = frame_end;
      bus.an = scan ? (sel ? 2'b10 : 2'b01) : 2'b00;
      bus.seg = !scan || (BLANK_LZ && sel && d1_q == 4'd0) ? 7'd0 : enc(digit);
      state_nxt = !bus.en ? IDLE : xfer ? LOAD : state == LOAD ? SCAN : state;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         val_q <= '0;
         d1_q <= '0;
         d0_q <= '0;
         div <= '0;
         sel <= 1'b0;
      end else begin
         state <= state_nxt;
         if (xfer) val_q <= bus.value_in;
         if (state == LOAD) begin
            d1_q <= out1;
            d0_q <= out0;
            div <= '0;
            sel <= 1'b0;
         end else if (scan) begin
            div <= div == DIV_LAST ? '0 : div + 1'b1;
            if (div == DIV_LAST) sel <= ~sel;
         end
      end
   end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed and random stimulus against a digit/phase model
module tb_bcd_display_scanner;
   localparam int SD = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   bit rst_req = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   bcd_display_scanner_if bus ();
   bcd_display_scanner_if bus0 ();
   assign bus0.en = bus.en;
   assign bus0.in_valid = bus.in_valid;
   assign bus0.value_in = bus.value_in;
   bcd_display_scanner #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   bcd_display_scanner #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   always #5 clk = ~clk;
   logic [6:0] enc_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
   // model: mode 0 idle, 1 load, 2 scan; m_ph = cycle index within a 2*SD frame
   int m_mode = 0, m_val = 0, m_tens = 0, m_ones = 0, m_ph = 0;
   bit m_xfer = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic step(input bit e, input bit v, input logic [4:0] d);
      bit scan, hi, fd, rdy;
      int dig;
      logic [6:0] s, s0;
      @(negedge clk);
      rst_n = rst_req;
      bus.en = e;
      bus.in_valid = v;
      bus.value_in = d;
      #1;
      scan = m_mode == 2;
      hi = m_ph >= SD;
      dig = hi ? m_tens : m_ones;
      fd = scan && m_ph == 2 * SD - 1;
      rdy = e && (m_mode == 0 || fd);
      s0 = scan ? enc_tab[dig] : 7'd0;
      s = (hi && m_tens == 0) ? 7'd0 : s0;
      chk("an", 32'(bus.an), scan ? (hi ? 2 : 1) : 0);
      chk("seg", 32'(bus.seg), 32'(s));
      chk("seg_nolz", 32'(bus0.seg), 32'(s0));
      chk("frame_done", 32'(bus.frame_done), 32'(fd));
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      @(posedge clk);
      m_xfer = rst_n && v && rdy;
      if (!rst_n) begin
         m_mode = 0; m_val = 0; m_tens = 0; m_ones = 0; m_ph = 0;
      end else begin
         if (m_mode == 1) begin
            m_tens = m_val / 10;
            m_ones = m_val % 10;
            m_ph = 0;
         end else if (m_mode == 2) m_ph = (m_ph + 1) % (2 * SD);
         if (m_xfer) m_val = int'(d);
         m_mode = !e ? 0 : m_xfer ? 1 : m_mode == 1 ? 2 : m_mode;
      end
   endtask

   task automatic send(input logic [4:0] d);
      bit done;
      done = 0;
      for (int k = 0; k < 4 * SD + 4 && !done; k++) begin
         step(1, 1, d);
         done = m_xfer;
      end
      chk("accept_timeout", 32'(done), 1);
   endtask

   initial begin
      bus.en = 1'b1;
      bus.in_valid = 1'b0;
      bus.value_in = '0;
      @(posedge clk);
      step(1, 0, 0);
      rst_req = 1'b1;
      repeat (2) step(1, 0, 0);
      send(31);
      repeat (4 * SD + 2) step(1, 0, 0);
      send(7);
      repeat (2 * SD + 1) step(1, 0, 0);
      send(12);
      repeat (3) step(1, 0, 0);
      send(19);
      repeat (2 * SD + 2) step(1, 0, 0);
      send(5);
      repeat (3) step(1, 0, 0);
      step(0, 0, 0);
      repeat (3) step(0, 1, 9);
      send(23);
      repeat (4) step(1, 0, 0);
      rst_req = 1'b0;
      step(1, 0, 0);
      rst_req = 1'b1;
      step(1, 0, 0);
      for (int v = 0; v < 32; v++) send(5'(v));
      repeat (2 * SD + 1) step(1, 0, 0);
      for (int i = 0; i < 400; i++) begin
         rst_req = $urandom_range(63) != 0;
         step($urandom_range(15) != 0, 1'($urandom_range(1)), 5'($urandom_range(31)));
      end
      rst_req = 1'b1;
      repeat (2) step(1, 0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
